// File: rtl/mc_rr_fifo.sv
// Multi-channel FIFO: one circular buffer per input channel, drained through a
// single output by a round-robin arbiter that holds its grant while stalled.
module mc_rr_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int AFULL_LVL = DEPTH - 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_chan,
  output logic [CHANNELS-1:0]        almost_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem  [CHANNELS][DEPTH];
  logic [PTR_W-1:0]  r_wptr [CHANNELS];
  logic [PTR_W-1:0]  r_rptr [CHANNELS];
  logic [CNT_W-1:0]  r_cnt  [CHANNELS];

  logic [CH_W-1:0]     r_last;
  logic [CH_W-1:0]     r_hold;
  logic                r_lock;

  logic [CHANNELS-1:0] w_nonempty;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_pop;
  logic [CH_W-1:0]     w_grant;
  logic                w_found;
  logic                w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_nonempty[gi]  = (r_cnt[gi] != '0);
      assign in_ready[gi]    = rst_n && (r_cnt[gi] < CNT_W'(DEPTH));
      assign almost_full[gi] = (r_cnt[gi] >= CNT_W'(AFULL_LVL));
      assign w_push[gi]      = in_valid[gi] && in_ready[gi];
      assign w_pop[gi]       = w_fire && (w_grant == CH_W'(gi));

      // Storage is never reset; the counts alone decide what is valid.
      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[gi][r_wptr[gi]] <= in_data[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr[gi] <= '0;
          r_rptr[gi] <= '0;
          r_cnt[gi]  <= '0;
        end else begin
          if (w_push[gi]) r_wptr[gi] <= r_wptr[gi] + 1'b1;
          if (w_pop[gi])  r_rptr[gi] <= r_rptr[gi] + 1'b1;
          r_cnt[gi] <= r_cnt[gi] + CNT_W'(w_push[gi]) - CNT_W'(w_pop[gi]);
        end
      end
    end
  endgenerate

  // Downward scan so the nearest channel after r_last is the final winner.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = (int'(r_last) + i) % CHANNELS;
      if (w_nonempty[idx]) begin
        w_grant = CH_W'(idx);
        w_found = 1'b1;
      end
    end
    if (r_lock) begin
      w_grant = r_hold;
      w_found = 1'b1;
    end
  end

  assign w_fire    = w_found && out_ready;
  assign out_valid = w_found;
  assign out_chan  = w_grant;
  assign out_data  = w_found ? r_mem[w_grant][r_rptr[w_grant]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= CH_W'(CHANNELS - 1);
      r_hold <= '0;
      r_lock <= 1'b0;
    end else if (w_fire) begin
      r_last <= w_grant;
      r_lock <= 1'b0;
    end else if (w_found) begin
      r_hold <= w_grant;
      r_lock <= 1'b1;
    end
  end

endmodule
